sub_status_collector: RTL and testbench

- Sits directly downstream of the Sub instance and consumes its per-cycle status outputs.
- Samples a_NO, f4_dotnamed, bign1_dotnamed and bign2_dotnamed whenever the strobe c_dotnamed is high, and packs them into one 10-bit record.
- Buffers records in a small FIFO and presents them on a valid/ready stream to the consumer.
- Tracks drops (overflow count) and the peak FIFO occupancy (high-water mark), both readable by software.

---
 rtl/sub_status_pkg.sv | 28 ++
 rtl/sub_status_fifo.sv | 72 +++++++
 rtl/sub_status_collector.sv | 89 ++++++++
 tb/tb_sub_status_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_status_pkg.sv
// Shared widths, record layout and parity helper for the Sub status collector.
// Build option SUB_STATUS_COLLECTOR_PARITY_EN widens the stored record by a parity bit.
package sub_status_pkg;

  localparam int A_W   = 3;
  localparam int F4_W  = 4;
  localparam int B2_W  = 2;
  localparam int PAY_W = A_W + F4_W + B2_W + 1;

`ifdef SUB_STATUS_COLLECTOR_PARITY_EN
  localparam int REC_W = PAY_W + 1;
`else
  localparam int REC_W = PAY_W;
`endif

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [F4_W-1:0] f4;
    logic [B2_W-1:0] bign2;
    logic            bign1;
  } sub_status_rec_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic rec_parity(input sub_status_rec_t rec);
    return ^rec;
  endfunction

endpackage

// File: rtl/sub_status_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from registered storage.
// Also exports the next-cycle occupancy so the parent can track a high-water mark.
module sub_status_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] level_nxt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_acc, wr_acc;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_acc = rd_en_i && !empty_o && !flush_i;
  assign wr_acc = wr_en_i && !flush_i && (!full_o || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Masking with empty keeps the output at zero after reset without clearing storage.
  assign rd_data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/sub_status_collector.sv
// Captures strobed Sub status into records, buffers them, and counts drops / peak occupancy.
// Define SUB_STATUS_COLLECTOR_PARITY_EN to append an even-parity bit (LSB) to each record.
module sub_status_collector
  import sub_status_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_W-1:0]   a_NO,
  input  logic [F4_W-1:0]  f4_dotnamed,
  input  logic             bign1_dotnamed,
  input  logic [B2_W-1:0]  bign2_dotnamed,
  input  logic             c_dotnamed,
  input  logic             etmp_dotnamed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic [LVL_W-1:0] hwm,
  output logic [CNT_W-1:0] overflow_cnt
);

  sub_status_rec_t  rec;
  logic [REC_W-1:0] rec_word;
  logic             empty, full, pop, push, drop;
  logic [LVL_W-1:0] level_nxt;
  logic [LVL_W-1:0] hwm_q, hwm_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  assign rec = {a_NO, f4_dotnamed, bign2_dotnamed, bign1_dotnamed};

`ifdef SUB_STATUS_COLLECTOR_PARITY_EN
  assign rec_word = {rec, rec_parity(rec)};
`else
  assign rec_word = rec;
`endif

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = c_dotnamed && !etmp_dotnamed && (!full || pop);
  assign drop      = c_dotnamed && !etmp_dotnamed && full && !pop;

  sub_status_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (etmp_dotnamed),
    .wr_en_i     (push),
    .wr_data_i   (rec_word),
    .rd_en_i     (pop),
    .rd_data_o   (out_data),
    .empty_o     (empty),
    .full_o      (full),
    .level_o     (fifo_level),
    .level_nxt_o (level_nxt)
  );

  always_comb begin
    hwm_d = hwm_q;
    ovf_d = ovf_q;
    if (etmp_dotnamed) begin
      hwm_d = '0;
      ovf_d = '0;
    end else begin
      if (level_nxt > hwm_q) hwm_d = level_nxt;
      if (drop && (ovf_q != {CNT_W{1'b1}})) ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
      ovf_q <= '0;
    end else begin
      hwm_q <= hwm_d;
      ovf_q <= ovf_d;
    end
  end

  assign hwm          = hwm_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_sub_status_collector.sv
// Self-checking bench: constant vector table, directed corner sequences, and random traffic vs a queue model.
module tb_sub_status_collector;
  import sub_status_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 8;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, c, fl, rdy;
  logic [2:0]       a;
  logic [3:0]       f4;
  logic             b1;
  logic [1:0]       b2;
  logic             out_valid;
  logic [REC_W-1:0] out_data;
  logic [LVL_W-1:0] lvl, hwm;
  logic [CNT_W-1:0] ovf;

  int nchk = 0;
  int nerr = 0;

  logic [9:0] mq[$];
  int m_ovf = 0;
  int m_hwm = 0;

  sub_status_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LVL_W(LVL_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_NO           (a),
    .f4_dotnamed    (f4),
    .bign1_dotnamed (b1),
    .bign2_dotnamed (b2),
    .c_dotnamed     (c),
    .etmp_dotnamed  (fl),
    .out_valid      (out_valid),
    .out_ready      (rdy),
    .out_data       (out_data),
    .fifo_level     (lvl),
    .hwm            (hwm),
    .overflow_cnt   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, c, f, rdy, pay, ev, el, eh, eo, ep;
  } vec_t;
  vec_t tv[10];

  function automatic logic [REC_W-1:0] enc(input logic [9:0] p);
`ifdef SUB_STATUS_COLLECTOR_PARITY_EN
    return {p, ^p};
`else
    return p;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic cc, input logic ff, input logic rr,
                       input logic [9:0] p);
    rst = r; c = cc; fl = ff; rdy = rr;
    a = p[9:7]; f4 = p[6:3]; b2 = p[2:1]; b1 = p[0];
  endtask

  // One clock: model absorbs the inputs seen at the edge, then DUT is compared 1ns later.
  task automatic cyc();
    logic [9:0] p;
    bit pop, full;
    @(posedge clk);
    p    = {a, f4, b2, b1};
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == DEPTH);
    if (rst || fl) begin
      mq.delete();
      m_ovf = 0;
      m_hwm = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (c) begin
        if (!full || pop) mq.push_back(p);
        else if (m_ovf < OVF_MAX) m_ovf++;
      end
      if (mq.size() > m_hwm) m_hwm = mq.size();
    end
    #1;
    chk("model_valid", out_valid, mq.size() != 0);
    chk("model_level", lvl, mq.size());
    chk("model_hwm", hwm, m_hwm);
    chk("model_ovf", ovf, m_ovf);
    chk("model_data", out_data, (mq.size() != 0) ? enc(mq[0]) : '0);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 0, 10'((base + i) * 37 + 5));
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] expq[$];
    drive(0, 0, 0, 0, 0);

    // r  c  f  rdy pay     ev el eh eo ep
    tv[0] = '{1, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    tv[1] = '{0, 1, 0, 1, 'h2D5, 1, 1, 1, 0, 'h2D5};
    tv[2] = '{0, 1, 0, 1, 'h2D5, 1, 1, 1, 0, 'h2D5};
    tv[3] = '{0, 1, 0, 1, 'h2D5, 1, 1, 1, 0, 'h2D5};
    tv[4] = '{0, 0, 0, 1, 0,     0, 0, 1, 0, 0};
    tv[5] = '{0, 1, 0, 0, 'h096, 1, 1, 1, 0, 'h096};
    tv[6] = '{0, 1, 0, 0, 'h3F8, 1, 2, 2, 0, 'h096};
    tv[7] = '{0, 0, 0, 1, 0,     1, 1, 2, 0, 'h3F8};
    tv[8] = '{0, 1, 1, 0, 'h155, 0, 0, 0, 0, 0};
    tv[9] = '{0, 0, 0, 1, 0,     0, 0, 0, 0, 0};

    for (int i = 0; i < 10; i++) begin
      drive(tv[i].r[0], tv[i].c[0], tv[i].f[0], tv[i].rdy[0], 10'(tv[i].pay));
      cyc();
      chk("tv_valid", out_valid, tv[i].ev);
      chk("tv_level", lvl, tv[i].el);
      chk("tv_hwm", hwm, tv[i].eh);
      chk("tv_ovf", ovf, tv[i].eo);
      chk("tv_data", out_data, enc(10'(tv[i].ep)));
    end

    // Ten strobes into an 8-deep FIFO with no consumer, then push+pop while full.
    drive(1, 0, 0, 0, 0); cyc();
    fill(10, 0);
    chk("fill_level", lvl, 8);
    chk("fill_hwm", hwm, 8);
    chk("fill_ovf", ovf, 2);
    drive(0, 1, 0, 1, 10'h2AA); cyc();
    chk("full_pp_level", lvl, 8);
    chk("full_pp_ovf", ovf, 2);
    expq.delete();
    for (int i = 1; i < 8; i++) expq.push_back(10'(i * 37 + 5));
    expq.push_back(10'h2AA);
    for (int k = 0; k < 8; k++) begin
      chk("drain_order", out_data, enc(expq[k]));
      drive(0, 0, 0, 1, 0); cyc();
    end
    chk("drain_empty", out_valid, 0);

    // Saturation of the drop counter.
    drive(1, 0, 0, 0, 0); cyc();
    fill(8, 3);
    fill(255, 50);
    chk("sat_at_max", ovf, OVF_MAX);
    fill(45, 9);
    chk("sat_hold", ovf, OVF_MAX);
    chk("sat_level", lvl, 8);

    // Flush with four queued, nonzero hwm/ovf, and a strobe in the flush cycle.
    drive(1, 0, 0, 0, 0); cyc();
    fill(10, 20);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0); cyc();
    end
    drive(0, 0, 0, 0, 0); cyc();
    chk("pre_flush_level", lvl, 4);
    drive(0, 1, 1, 0, 10'h1C3); cyc();
    chk("flush_valid", out_valid, 0);
    chk("flush_level", lvl, 0);
    chk("flush_hwm", hwm, 0);
    chk("flush_ovf", ovf, 0);
    drive(0, 0, 0, 1, 0); cyc();
    chk("flush_rec_absent", out_valid, 0);

    // Record encoding, including the parity variant.
    drive(0, 1, 0, 0, 10'h2D5); cyc();
`ifdef SUB_STATUS_COLLECTOR_PARITY_EN
    chk("enc_2d5", out_data, 'h5AA);
`else
    chk("enc_2d5", out_data, 'h2D5);
`endif
    drive(0, 1, 0, 1, 10'h001); cyc();
`ifdef SUB_STATUS_COLLECTOR_PARITY_EN
    chk("enc_001", out_data, 'h003);
`else
    chk("enc_001", out_data, 'h001);
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 60, $urandom_range(99) < 3,
            $urandom_range(99) < ((i / 300) % 2 == 0 ? 30 : 70), 10'($urandom));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
